// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Lookup / refill controller that sits directly downstream of the I-cache tag
// array (21-bit entries {valid, tag[19:0]}, 128 sets indexed by addr[11:5],
// 32-byte lines).
//
// A fetch is accepted in IDLE, or in LOOKUP while the previous fetch hits, so
// consecutive hits stream at one fetch per cycle. On a miss the controller
// issues one AXI-style line read and writes every beat into the data RAM. It
// then writes the tag entry and returns the requested word, which it captured
// while the beats went past.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   cpu_req / cpu_addr        fetch request and word-aligned byte address
//   cpu_addr_ok               request accepted this cycle
//   cpu_data_ok / cpu_rdata   instruction word valid this cycle
//   tag_raddr                 lookup address to the tag array (follows cpu_addr)
//   tag_waddr/tag_wen/tag_wdata  tag entry write port; tag_op is tied low
//   tag_hit / tag_valid       registered compare result for the last tag_raddr
//   tag_work                  tag array has finished its clear sweep
//   data_index                data RAM set index
//   data_wen / data_wdata     per-word write strobes and refill word
//   data_rdata                whole line, one cycle after data_index
//   ar_*                      read address channel (line aligned, BURST_LEN)
//   r_*                       read data channel
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int BURST_LEN  = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    // fetch interface
    input  logic                     cpu_req,
    input  logic [31:0]              cpu_addr,
    output logic                     cpu_addr_ok,
    output logic                     cpu_data_ok,
    output logic [31:0]              cpu_rdata,
    // tag array
    output logic [31:0]              tag_raddr,
    output logic [31:0]              tag_waddr,
    output logic [3:0]               tag_wen,
    output logic [20:0]              tag_wdata,
    output logic                     tag_op,
    input  logic                     tag_hit,
    input  logic                     tag_valid,
    input  logic                     tag_work,
    // data RAM
    output logic [6:0]               data_index,
    output logic [LINE_WORDS-1:0]    data_wen,
    output logic [31:0]              data_wdata,
    input  logic [LINE_WORDS*32-1:0] data_rdata,
    // line read channel
    output logic                     ar_valid,
    output logic [31:0]              ar_addr,
    output logic [7:0]               ar_len,
    input  logic                     ar_ready,
    input  logic                     r_valid,
    input  logic [31:0]              r_data,
    output logic                     r_ready
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_REFILL,
        S_WRITE_TAG
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      pend_word_q;

    logic             lookup_hit;
    logic [CNT_W-1:0] req_word;
    logic             accept;

    assign lookup_hit = tag_hit & tag_valid;
    assign req_word   = req_addr_q[CNT_W+1:2];

    // The tag array always looks up whatever the IF stage presents; the result
    // is only consumed in LOOKUP after an accept.
    assign tag_raddr  = cpu_addr;
    assign tag_op     = 1'b0;
    assign ar_len     = 8'(BURST_LEN);

    // During refill the data RAM is written at the missed line. Otherwise it is
    // read at the incoming address so the line is ready one cycle later.
    assign data_index = (state_q == S_REFILL) ? req_addr_q[11:5] : cpu_addr[11:5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            beat_cnt_q <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            req_addr_q <= req_addr_d;
        end
    end

    // NOTE: pure datapath register with no reset. It is written by the
    // requested beat before WRITE_TAG ever reads it, so a reset value would
    // only cost flops and add fan-out on rst.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL && r_valid && beat_cnt_q == req_word) begin
            pend_word_q <= r_data;
        end
    end

    // NOTE: every output and next-state signal gets a default first, with
    // blocking assignments, so no path through the case below can infer a latch.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        req_addr_d  = req_addr_q;
        accept      = 1'b0;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        tag_waddr   = '0;
        tag_wen     = '0;
        tag_wdata   = '0;
        data_wen    = '0;
        data_wdata  = '0;
        ar_valid    = 1'b0;
        ar_addr     = '0;
        r_ready     = 1'b0;

        case (state_q)
            S_INIT: begin
                if (tag_work) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (cpu_req) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (lookup_hit) begin
                    // data_rdata was read at this request's index in the accept cycle.
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = data_rdata[{req_word, 5'b0} +: 32];
                    if (cpu_req) begin
                        accept  = 1'b1;
                        state_d = S_LOOKUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_MISS_AR;
                end
            end

            S_MISS_AR: begin
                ar_valid = 1'b1;
                ar_addr  = {req_addr_q[31:5], 5'b0};
                if (ar_ready) begin
                    beat_cnt_d = '0;
                    state_d    = S_REFILL;
                end
            end

            S_REFILL: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    data_wen   = LINE_WORDS'(1) << beat_cnt_q;
                    data_wdata = r_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // The beat count alone decides completion; the bus carries no last flag.
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_WRITE_TAG;
                    end
                end
            end

            S_WRITE_TAG: begin
                // No accept here, so the next lookup already sees the new tag.
                tag_wen     = 4'hF;
                tag_waddr   = req_addr_q;
                tag_wdata   = {1'b1, req_addr_q[31:12]};
                cpu_data_ok = 1'b1;
                cpu_rdata   = pend_word_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        if (accept) begin
            cpu_addr_ok = 1'b1;
            req_addr_d  = cpu_addr;
        end
    end

endmodule
